rib_periph_bridge: RTL and testbench

- Single-master to N-slave RIB bridge. Sits directly upstream of the peripheral slaves (timer, and later GPIO and UART) on the peripheral bus.
- Decodes the peripheral region, forwards one transaction at a time to the selected slave, and returns the slave's read data to the master.
- Returns an error response for unmapped addresses and for slave timeouts, so a dead peripheral never hangs the core.

---
 rtl/rib_periph_bridge.sv | 165 ++++++++++++++++
 tb/tb_rib_periph_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rib_periph_bridge.sv
// Peripheral-region bridge: one master, N_SLV slaves, one transaction in flight.
// Unmapped accesses and unresponsive slaves are answered with an error so the
// core never stalls on a dead peripheral.
module rib_periph_bridge #(
  parameter int          N_SLV       = 4,
  parameter logic [15:0] REGION      = 16'h4000,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [31:0]         i_ribm_addr,
  input  logic                i_ribm_wrcs,
  input  logic [3:0]          i_ribm_mask,
  input  logic [31:0]         i_ribm_wdata,
  input  logic                i_ribm_req,
  output logic                o_ribm_gnt,
  output logic [31:0]         o_ribm_rdata,
  output logic                o_ribm_rsp,
  output logic                o_ribm_err,
  input  logic                i_ribm_rdy,
  output logic [31:0]         o_ribs_addr,
  output logic                o_ribs_wrcs,
  output logic [3:0]          o_ribs_mask,
  output logic [31:0]         o_ribs_wdata,
  output logic [N_SLV-1:0]    o_ribs_req,
  input  logic [N_SLV-1:0]    i_ribs_gnt,
  input  logic [32*N_SLV-1:0] i_ribs_rdata,
  input  logic [N_SLV-1:0]    i_ribs_rsp,
  output logic [N_SLV-1:0]    o_ribs_rdy
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SREQ, SWAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [11:0]       addr_q, addr_d;
  logic              wrcs_q, wrcs_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              gnt_sel, rsp_sel, mapped, timeout;
  logic [31:0]       rdata_sel;

  // Route the selected slave's handshake/data and drive the one-hot strobes.
  always_comb begin
    gnt_sel    = 1'b0;
    rsp_sel    = 1'b0;
    rdata_sel  = '0;
    o_ribs_req = '0;
    o_ribs_rdy = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (sel_q == 4'(k)) begin
        gnt_sel       = i_ribs_gnt[k];
        rsp_sel       = i_ribs_rsp[k];
        rdata_sel     = i_ribs_rdata[32*k +: 32];
        o_ribs_req[k] = (state_q == SREQ);
        o_ribs_rdy[k] = (state_q == SREQ) || (state_q == SWAIT);
      end
    end
  end

  assign mapped  = (i_ribm_addr[31:16] == REGION) &&
                   ({1'b0, i_ribm_addr[15:12]} < 5'(N_SLV));
  assign timeout = (cnt_q == CNT_LAST);

  // Next-state logic; a response from the slave beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wrcs_d  = wrcs_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (i_ribm_req) begin
          addr_d  = i_ribm_addr[11:0];
          wrcs_d  = i_ribm_wrcs;
          mask_d  = i_ribm_mask;
          wdata_d = i_ribm_wdata;
          sel_d   = i_ribm_addr[15:12];
          if (mapped) begin
            state_d = SREQ;
            cnt_d   = '0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SREQ: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end else if (gnt_sel) begin
          state_d = SWAIT;
        end
      end
      SWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (rsp_sel) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = rdata_sel;
        end else if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end
      end
      RESP: begin
        if (i_ribm_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched transaction registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wrcs_q  <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wrcs_q  <= wrcs_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_ribm_gnt   = (state_q == IDLE);
  assign o_ribm_rsp   = (state_q == RESP);
  assign o_ribm_rdata = rdata_q;
  assign o_ribm_err   = err_q;
  assign o_ribs_addr  = {20'b0, addr_q};
  assign o_ribs_wrcs  = wrcs_q;
  assign o_ribs_mask  = mask_q;
  assign o_ribs_wdata = wdata_q;

endmodule

// File: tb/tb_rib_periph_bridge.sv
// Bench for rib_periph_bridge: timer-like slave models, scoreboard of expected
// master responses, latency and slave-side checks.
module tb_rib_periph_bridge;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   m_addr;
  logic          m_wrcs;
  logic [3:0]    m_mask;
  logic [31:0]   m_wdata;
  logic          m_req;
  logic          m_gnt;
  logic [31:0]   m_rdata;
  logic          m_rsp;
  logic          m_err;
  logic          m_rdy;
  logic [31:0]   s_addr;
  logic          s_wrcs;
  logic [3:0]    s_mask;
  logic [31:0]   s_wdata;
  logic [N-1:0]  s_req;
  logic [N-1:0]  s_gnt;
  logic [32*N-1:0] s_rdata;
  logic [N-1:0]  s_rsp;
  logic [N-1:0]  s_rdy;

  logic [N-1:0]  rsp_q = '0;
  logic [N-1:0]  dead;
  logic [N-1:0]  stray;

  int            total = 0;
  int            bad = 0;
  logic [32:0]   exp_q[$];

  int            pulse_cnt[N];
  int            pc_before[N];
  logic [31:0]   log_addr, log_wdata;
  logic          log_wrcs;
  logic [3:0]    log_mask;

  always #5 clk = ~clk;

  rib_periph_bridge #(.N_SLV(N), .REGION(16'h4000), .TIMEOUT_CYC(64),
                      .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_ribm_addr(m_addr), .i_ribm_wrcs(m_wrcs), .i_ribm_mask(m_mask),
    .i_ribm_wdata(m_wdata), .i_ribm_req(m_req), .o_ribm_gnt(m_gnt),
    .o_ribm_rdata(m_rdata), .o_ribm_rsp(m_rsp), .o_ribm_err(m_err),
    .i_ribm_rdy(m_rdy),
    .o_ribs_addr(s_addr), .o_ribs_wrcs(s_wrcs), .o_ribs_mask(s_mask),
    .o_ribs_wdata(s_wdata), .o_ribs_req(s_req), .i_ribs_gnt(s_gnt),
    .i_ribs_rdata(s_rdata), .i_ribs_rsp(s_rsp), .o_ribs_rdy(s_rdy)
  );

  // Slaves grant combinationally and answer one cycle later, like the timer.
  assign s_gnt   = s_req;
  assign s_rsp   = rsp_q | stray;
  assign s_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_1234};

  always_ff @(posedge clk) rsp_q <= s_req & s_gnt & ~dead;

  initial for (int k = 0; k < N; k++) pulse_cnt[k] = 0;

  // Record what a slave sees when it grants.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (s_req[k] && s_gnt[k]) begin
        pulse_cnt[k] = pulse_cnt[k] + 1;
        log_addr     = s_addr;
        log_wrcs     = s_wrcs;
        log_mask     = s_mask;
        log_wdata    = s_wdata;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one transaction from just after a posedge and follow it to completion.
  task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                     input int hold, input logic [N-1:0] exp_pulse);
    int n;
    logic [31:0] rd0;
    logic err0;
    logic [N-1:0] pulsed;
    for (int k = 0; k < N; k++) pc_before[k] = pulse_cnt[k];
    exp_q.push_back({exp_err, exp_rd});
    m_addr  = addr;
    m_wrcs  = wr;
    m_wdata = wd;
    m_mask  = 4'hF;
    m_req   = 1'b1;
    @(negedge clk);
    chk("gnt_idle", 64'(m_gnt), 64'd1);
    @(posedge clk);
    #1;
    m_req = 1'b0;
    if (hold > 0) m_rdy = 1'b0;
    n = 1;
    @(negedge clk);
    while (!m_rsp && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    rd0  = m_rdata;
    err0 = m_err;
    for (int i = 0; i < hold; i++) begin
      chk("hold_rsp", {m_gnt, m_rsp, m_err, m_rdata}, {1'b0, 1'b1, err0, rd0});
      @(posedge clk);
      @(negedge clk);
    end
    m_rdy = 1'b1;
    chk("resp", 64'({m_err, m_rdata}), 64'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    chk("back_idle", {m_gnt, m_rsp}, 2'b10);
    for (int k = 0; k < N; k++) pulsed[k] = (pulse_cnt[k] - pc_before[k]) == 1;
    chk("slv_pulse", 64'(pulsed), 64'(exp_pulse));
  endtask

  initial begin
    rstn = 1'b0; m_addr = '0; m_wrcs = 1'b0; m_mask = '0; m_wdata = '0;
    m_req = 1'b0; m_rdy = 1'b1; dead = '0; stray = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m", {m_gnt, m_rsp, m_err, m_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
    chk("rst_s", {s_req, s_rdy, s_addr, s_wdata}, '0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Timer-like read of slave 0.
    txn(32'h4000_0004, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 3, 0, 4'b0001);
    chk("rd_slv_addr", {log_wrcs, log_addr}, {1'b0, 32'h4});

    // Write to slave 1; read data is captured anyway.
    txn(32'h4000_1008, 1'b1, 32'hA5A5_0001, 32'h1111_0001, 1'b0, 3, 0, 4'b0010);
    chk("wr_slv", {log_wrcs, log_mask, log_addr, log_wdata},
        {1'b1, 4'hF, 32'h8, 32'hA5A5_0001});

    // Unmapped: outside region, and sel beyond N_SLV.
    txn(32'h5000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 4'b0000);
    txn(32'h4000_7000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 4'b0000);

    // Slave 2 never answers: timeout 64 cycles after SREQ entry.
    dead[2] = 1'b1;
    txn(32'h4000_2000, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 65, 0, 4'b0100);
    // Late response from slave 2 in IDLE and during a slave-0 transaction.
    stray[2] = 1'b1;
    @(posedge clk);
    #1;
    chk("late_rsp_idle", {m_gnt, m_rsp}, 2'b10);
    txn(32'h4000_0010, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 3, 0, 4'b0001);
    stray[2] = 1'b0;
    dead[2]  = 1'b0;

    // Master holds off the response for 5 cycles.
    txn(32'h4000_3010, 1'b0, 32'h0, 32'h3333_0003, 1'b0, 3, 5, 4'b1000);

    // Reset while waiting in SWAIT aborts with no response.
    dead[3] = 1'b1;
    m_addr = 32'h4000_3000; m_wrcs = 1'b0; m_req = 1'b1;
    @(posedge clk);
    #1;
    m_req = 1'b0;
    @(posedge clk);
    #1;
    chk("swait_strobes", {s_req, s_rdy, m_rsp}, {4'b0000, 4'b1000, 1'b0});
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_abort", {s_req, s_rdy, m_rsp, m_err, m_gnt, m_rdata},
        {4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_rsp", {m_rsp, s_req}, '0);
    dead[3] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
